// File: rtl/skullfet_tester.sv
// Stimulus generator and response checker for the SKULLFET inverter cell.
// Drives A, samples a synchronised Y and accumulates pass/fail statistics per run.
module skullfet_tester #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             active,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] num_vectors,
    output logic             dut_a,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [15:0]      LfsrSeed   = 16'hACE1;
    localparam logic [7:0]       SettleLoad = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AllOnes    = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   first_q, first_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [7:0]         settle_q, settle_d;
    logic               dut_a_q, dut_a_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               y_meta_q, y_s_q;

    logic               pattern_bit;
    logic               lfsr_fb;
    logic               mismatch;
    logic [CNT_W-1:0]   vec_inc;

    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    // A healthy cell drives Y = ~A, so equality means a fault.
    assign mismatch = (y_s_q == dut_a_q);
    assign vec_inc  = vec_q + 1'b1;

    always_comb begin
        unique case (mode_q)
            2'd0:    pattern_bit = vec_q[0];
            2'd1:    pattern_bit = lfsr_q[0];
            2'd2:    pattern_bit = 1'b0;
            default: pattern_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        num_d    = num_q;
        err_d    = err_q;
        vec_d    = vec_q;
        first_d  = first_q;
        lfsr_d   = lfsr_q;
        settle_d = settle_q;
        dut_a_d  = dut_a_q;
        done_d   = 1'b0;
        pass_d   = pass_q;

        case (state_q)
            StIdle: begin
                if (start && active) begin
                    mode_d  = mode;
                    num_d   = num_vectors;
                    err_d   = '0;
                    vec_d   = '0;
                    first_d = AllOnes;
                    lfsr_d  = LfsrSeed;
                    state_d = (num_vectors == '0) ? StDone : StDrive;
                end
            end
            StDrive: begin
                dut_a_d  = pattern_bit;
                settle_d = SettleLoad;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == 8'd0) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            StSample: begin
                if (mismatch) begin
                    if (err_q != AllOnes) begin
                        err_d = err_q + 1'b1;
                    end
                    if (first_q == AllOnes) begin
                        first_d = vec_q;
                    end
                end
                vec_d   = vec_inc;
                lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
                state_d = (vec_inc == num_q) ? StDone : StDrive;
            end
            StDone: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Deselect aborts the run: partial results stay visible, no completion reported.
        if (!active && (state_q != StIdle)) begin
            state_d = StIdle;
            dut_a_d = 1'b0;
            done_d  = 1'b0;
            pass_d  = pass_q;
            err_d   = err_q;
            vec_d   = vec_q;
            first_d = first_q;
            lfsr_d  = lfsr_q;
        end

        busy_d = (state_d == StDrive) || (state_d == StSettle) || (state_d == StSample);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            mode_q   <= 2'd0;
            num_q    <= '0;
            err_q    <= '0;
            vec_q    <= '0;
            first_q  <= AllOnes;
            lfsr_q   <= LfsrSeed;
            settle_q <= 8'd0;
            dut_a_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            y_meta_q <= 1'b0;
            y_s_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            err_q    <= err_d;
            vec_q    <= vec_d;
            first_q  <= first_d;
            lfsr_q   <= lfsr_d;
            settle_q <= settle_d;
            dut_a_q  <= dut_a_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            y_meta_q <= dut_y;
            y_s_q    <= y_meta_q;
        end
    end

    assign dut_a         = dut_a_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign vec_count     = vec_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_skullfet_tester.sv
// Directed bench for skullfet_tester: inverter, buffer and stuck-at cell models,
// zero-length runs, deselect abort, reset mid-run and start-while-busy.
module tb_skullfet_tester;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned VEC_CYC = SETTLE + 2;

    logic        clk;
    logic        rst;
    logic        active;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] num_vectors;
    logic        dut_a;
    logic        dut_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] vec_count;
    logic [15:0] first_err_idx;

    // Cell model: 0 = inverter, 1 = buffer, 2 = stuck at 1.
    int ymode;
    int n_cmp;
    int n_mis;

    assign dut_y = (ymode == 0) ? ~dut_a : (ymode == 1) ? dut_a : 1'b1;

    skullfet_tester #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (16)
    ) u_dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .active       (active),
        .start        (start),
        .mode         (mode),
        .num_vectors  (num_vectors),
        .dut_a        (dut_a),
        .dut_y        (dut_y),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .vec_count    (vec_count),
        .first_err_idx(first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_dut_a"}, dut_a, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_err"}, err_count, 0);
        check_eq({tag, "_vec"}, vec_count, 0);
        check_eq({tag, "_first"}, first_err_idx, 16'hFFFF);
    endtask

    // Start is sampled at the edge this task ends on (edge 0).
    task automatic start_pulse(input logic [1:0] md, input int n);
        start       = 1'b1;
        mode        = md;
        num_vectors = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_vec(input string tag, input int target);
        int cyc;
        cyc = 0;
        while (vec_count != 16'(target) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq(tag, vec_count, target);
    endtask

    // Full run with a reference model of pattern and cell, checking timing and results.
    task automatic run_vectors(input string tag, input logic [1:0] md, input int n);
        int         cyc;
        int         k;
        int         a_bad;
        int         exp_err;
        int         exp_first;
        bit         got_done;
        bit         busy_seen;
        logic       a_exp;
        logic       y_exp;
        logic [15:0] lf;

        start_pulse(md, n);
        lf        = 16'hACE1;
        exp_err   = 0;
        exp_first = 16'hFFFF;
        a_bad     = 0;
        got_done  = 0;
        busy_seen = 0;
        cyc       = 0;
        while (!got_done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_seen = 1;
            if (((cyc - 1) % VEC_CYC) == 0 && ((cyc - 1) / VEC_CYC) < n) begin
                k = (cyc - 1) / VEC_CYC;
                case (md)
                    2'd0:    a_exp = k[0];
                    2'd1:    a_exp = lf[0];
                    2'd2:    a_exp = 1'b0;
                    default: a_exp = 1'b1;
                endcase
                if (dut_a !== a_exp) a_bad++;
                y_exp = (ymode == 0) ? ~a_exp : (ymode == 1) ? a_exp : 1'b1;
                if (y_exp !== ~a_exp) begin
                    exp_err++;
                    if (exp_first == 16'hFFFF) exp_first = k;
                end
                lf = lfsr_next(lf);
            end
            if (done) got_done = 1;
        end
        check_eq({tag, "_done_cycle"}, cyc, n * VEC_CYC + 1);
        check_eq({tag, "_a_seq_bad"}, a_bad, 0);
        check_eq({tag, "_err"}, err_count, exp_err);
        check_eq({tag, "_vec"}, vec_count, n);
        check_eq({tag, "_first"}, first_err_idx, exp_first);
        check_eq({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
        check_eq({tag, "_busy_seen"}, busy_seen, (n > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        int  cyc;
        bit  done_seen;

        n_cmp       = 0;
        n_mis       = 0;
        ymode       = 0;
        rst         = 1'b1;
        active      = 1'b1;
        start       = 1'b0;
        mode        = 2'd0;
        num_vectors = 16'd0;
        #2;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        ymode = 0;
        run_vectors("inv_toggle8", 2'd0, 8);
        check_eq("inv_toggle8_hand_err", err_count, 0);

        ymode = 1;
        run_vectors("buf_lfsr20", 2'd1, 20);
        check_eq("buf_lfsr20_hand_err", err_count, 20);

        ymode = 2;
        run_vectors("stk1_toggle8", 2'd0, 8);
        check_eq("stk1_toggle8_hand_err", err_count, 4);
        check_eq("stk1_toggle8_hand_first", first_err_idx, 1);

        ymode = 1;
        run_vectors("buf_const1", 2'd3, 3);
        ymode = 0;
        run_vectors("inv_const0", 2'd2, 2);

        run_vectors("zero_len", 2'd0, 0);

        // Abort during vector 3 while A is high; partial counts stay, pass holds.
        ymode = 2;
        start_pulse(2'd0, 8);
        wait_vec("abort_reach", 3);
        @(posedge clk);
        #1;
        check_eq("abort_pre_a", dut_a, 1);
        active = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_dut_a", dut_a, 0);
        check_eq("abort_vec", vec_count, 3);
        check_eq("abort_err", err_count, 1);
        check_eq("abort_first", first_err_idx, 1);
        check_eq("abort_pass", pass, 1);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen = 1;
        end
        check_eq("abort_quiet", done_seen, 0);
        active = 1'b1;
        ymode  = 0;
        run_vectors("after_abort", 2'd0, 4);

        // Start while busy is ignored; reset mid-settle clears everything at once.
        start_pulse(2'd0, 8);
        wait_vec("rst_reach", 1);
        start_pulse(2'd3, 1);
        check_eq("busy_start_busy", busy, 1);
        check_eq("busy_start_vec", vec_count, 1);
        check_eq("busy_start_a", dut_a, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrun_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (busy) cyc++;
        end
        check_eq("post_rst_idle", cyc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/skullfet_tester.md
# skullfet_tester

Self-checking stimulus generator and response checker for the SKULLFET inverter cell. It sits inside the user-project wrapper beside the inverter instances. It drives the inverter input `A`, samples the inverter output `Y` through a synchroniser, compares `Y` against the expected `~A`, and reports pass/fail counters on the logic-analyser bus. Firmware starts a run and reads the results, so the cell is characterised without external equipment.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: clock cycles between driving `A` and sampling `Y`; legal range 3..255.
- `CNT_W`, default 16: width of the vector, error and index counters.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `active`  in  1  project selected; low aborts any run.
- `start`  in  1  one-cycle request; honoured only in IDLE while `active`=1.
- `mode`  in  2  pattern: 0 = toggle, 1 = LFSR, 2 = const 0, 3 = const 1.
- `num_vectors`  in  CNT_W  vectors per run.
- `dut_a`  out  1  drives the inverter input.
- `dut_y`  in  1  inverter output; asynchronous to the clock.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  last completed run had zero errors.
- `err_count`  out  CNT_W  number of mismatches; saturates at all-ones.
- `vec_count`  out  CNT_W  number of vectors sampled.
- `first_err_idx`  out  CNT_W  index of the first mismatch; all-ones if none.

## Operation
- On `start`, the block latches `mode` and `num_vectors`. It clears `err_count` and `vec_count`, sets `first_err_idx` to all-ones, and reseeds the LFSR to 0xACE1.
- `dut_y` passes through a 2-flop synchroniser to give `y_s`.
- States:
  - IDLE: waits for `start`.
  - DRIVE (1 cycle): `dut_a` takes the pattern bit for vector `vec_count`.
  - SETTLE: lasts `SETTLE_CYCLES` cycles.
  - SAMPLE (1 cycle): compares `y_s` with `~dut_a`, increments `vec_count`, advances the LFSR.
  - DONE (1 cycle): pulses `done`, then returns to IDLE.
- Transitions:
  - IDLE goes to DRIVE on `start` with `num_vectors` ≠ 0.
  - IDLE goes directly to DONE on `start` with `num_vectors` = 0; `pass` is 1 and all counts are 0.
  - After SAMPLE, the block goes to DONE when the incremented `vec_count` equals `num_vectors`, otherwise to DRIVE.
- Pattern bit per mode:
  - toggle: `vec_count[0]`, giving 0,1,0,1,…
  - LFSR: bit 0 of a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - const 0 / const 1: the fixed bit.
- On a mismatch, `err_count` increments (saturating). If `first_err_idx` is still all-ones, it takes the index of the current vector (`vec_count` before increment).
- `pass` updates only in DONE and equals (`err_count` == 0).
- `busy` is 1 in DRIVE, SETTLE and SAMPLE.
- `active` low in any state other than IDLE forces IDLE on the next edge. In that case `done` does not pulse, `pass` is not updated, counters hold their partial values, and `dut_a` goes to 0.
- `start` is ignored while `busy`=1.

## Timing
- Reset values: `dut_a`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `vec_count`=0, `first_err_idx`=all-ones, state IDLE, LFSR=0xACE1. Reset takes effect immediately, including mid-run.
- Each vector takes `SETTLE_CYCLES`+2 cycles.
- With `start` sampled at edge 0:
  - `dut_a` for vector 0 is valid after edge 1.
  - `done` is high for the single cycle after edge N·(`SETTLE_CYCLES`+2)+1.
  - With N=0, `done` is high after edge 1.
- Results hold until the next accepted `start` or reset.
- The settle window of at least 3 cycles covers the 2-flop synchroniser plus one cycle of cell delay margin.

## Test plan
- Ideal inverter (`dut_y` = ~`dut_a`), toggle mode, N=8, `SETTLE_CYCLES`=4 -> `done` at cycle 49, `err_count`=0, `vec_count`=8, `first_err_idx`=0xFFFF, `pass`=1.
- Buffer model (`dut_y` = `dut_a`), LFSR mode, N=20 -> `err_count`=20, `first_err_idx`=0, `pass`=0; the `dut_a` sequence matches the LFSR reference model.
- `dut_y` stuck at 1, toggle mode, N=8 -> errors on vectors 1,3,5,7; `err_count`=4, `first_err_idx`=1, `pass`=0.
- N=0 -> `done` one cycle after `start`, `busy` never set, `pass`=1, counts 0.
- `active` dropped after vector 3 -> IDLE next cycle, no `done` pulse, `vec_count`=3, `dut_a`=0; a new `start` then runs cleanly.
- `wb_rst_i` pulsed mid-SETTLE, and `start` asserted while busy -> all outputs return immediately to their reset values; the busy-time `start` is ignored and `vec_count` is unaffected.
